// File: rtl/mul8_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mul8_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ITER  = 8;
   localparam int CNT_W = 3;

endpackage

// File: rtl/add8.sv
// 8-bit ripple-carry adder exposing every stage's carry-out.
// Latency: combinational, 8 cascaded full-adder stages.
// Backpressure: none, pure combinational.
module add8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic [7:0] carry
);

   // Ripple the carry through eight full adders, lsb first.
   always_comb begin
      logic c;
      c     = cin;
      sum   = '0;
      carry = '0;
      for (int i = 0; i < 8; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c;
         carry[i] = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
         c        = carry[i];
      end
   end

endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one add8 step per cycle.
// Latency: 8 cycles from the start edge to the done pulse; 9-cycle throughput.
// Backpressure: start is ignored while busy; a start during the done cycle chains.
module mul8_seq
   import mul8_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p,
   output logic        busy,
   output logic        done
);

   state_t             state;
   state_t             state_nxt;
   logic               load;
   logic               step;
   logic               last;

   logic [7:0]         mcand;
   logic [7:0]         acc_hi;
   logic [7:0]         acc_lo;
   logic [CNT_W-1:0]   cnt;

   logic [7:0]         addend;
   logic [7:0]         sum;
   logic [7:0]         carry;
   logic [15:0]        shift_nxt;
   logic               unused_carry;

   // Only the final carry feeds the shift; the inner ripple carries stay internal.
   assign unused_carry = ^carry[6:0];

   // Add the multiplicand only when the current multiplier bit is set.
   assign addend = acc_lo[0] ? mcand : 8'h00;

   add8 u_add8 (
      .a     (acc_hi),
      .b     (addend),
      .cin   (1'b0),
      .sum   (sum),
      .carry (carry)
   );

   // {carry, sum, acc_lo} shifted right by one; the dropped lsb is the consumed multiplier bit.
   assign shift_nxt = {carry[7], sum, acc_lo[7:1]};

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CNT_W'(ITER - 1)) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus datapath: load operands, iterate, capture the product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
         p      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= last;
         if (load) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            busy   <= 1'b1;
         end
         if (step) begin
            {acc_hi, acc_lo} <= shift_nxt;
            cnt              <= cnt + CNT_W'(1);
         end
         if (last) begin
            p    <= shift_nxt;
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mul8_seq.sv
// Scoreboarded bench for mul8_seq: directed cases, reset abort, random products.
// Latency: expects done 8 cycles after each accepted start.
// Backpressure: drives start only in IDLE or the DONE cycle, plus one ignored start while busy.
module tb_mul8_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic [15:0] p;
   logic        busy;
   logic        done;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] sb[$];
   logic [15:0] last_p = '0;

   mul8_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .p     (p),
      .busy  (busy),
      .done  (done)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled at the following posedge.
   task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input bit expect_it);
      a     = ia;
      b     = ib;
      start = 1'b1;
      if (expect_it) sb.push_back(16'(ia) * 16'(ib));
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
   endtask

   // Counts busy cycles until done is seen, bounded.
   task automatic wait_done(output int n);
      int k;
      n = 0;
      k = 0;
      while (!done && k < 20) begin
         if (busy) n++;
         k++;
         @(negedge clk);
      end
      if (!done) chk("done_timeout", {15'b0, done}, 16'd1);
   endtask

   // Output monitor: pop the scoreboard on done, otherwise p must hold.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_p = '0;
      end else if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", {15'b0, done}, 16'd0);
         end else begin
            chk("product", p, sb.pop_front());
         end
         last_p = p;
      end else begin
         chk("p_hold", p, last_p);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1);
   end

   initial begin
      int n;
      int nd;
      repeat (2) @(negedge clk);
      chk("rst_p", p, 16'h0000);
      chk("rst_busy", {15'b0, busy}, 16'd0);
      chk("rst_done", {15'b0, done}, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Zero operands; busy window is exactly 8 cycles.
      start_op(8'h00, 8'h00, 1'b1);
      chk("t1_busy_after_start", {15'b0, busy}, 16'd1);
      wait_done(n);
      chk("t1_busy_cycles", 16'(n), 16'd8);
      @(negedge clk);
      chk("t1_done_width", {15'b0, done}, 16'd0);

      // 0x5F*0xA2, then 0xAA*0xBB started during the DONE cycle.
      start_op(8'h5F, 8'hA2, 1'b1);
      wait_done(n);
      chk("t2_busy_cycles", 16'(n), 16'd8);
      start_op(8'hAA, 8'hBB, 1'b1);
      chk("t2_b2b_busy", {15'b0, busy}, 16'd1);
      wait_done(n);
      chk("t2_b2b_cycles", 16'(n), 16'd8);
      @(negedge clk);
      chk("t2_idle_busy", {15'b0, busy}, 16'd0);

      // Largest operands exercise the carry-out into the shift.
      start_op(8'hFF, 8'hFF, 1'b1);
      wait_done(n);
      chk("t3_busy_cycles", 16'(n), 16'd8);
      @(negedge clk);

      // A start raised mid-operation must be ignored.
      start_op(8'h5F, 8'hA2, 1'b1);
      repeat (2) @(negedge clk);
      a     = 8'h01;
      b     = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("t4_busy_left", 16'(n), 16'd5);
      @(negedge clk);
      chk("t4_no_restart", {15'b0, busy}, 16'd0);
      @(negedge clk);

      // Asynchronous reset between E4 and E5 aborts the operation.
      start_op(8'hFF, 8'hFF, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_p", p, 16'h0000);
      chk("t5_rst_busy", {15'b0, busy}, 16'd0);
      chk("t5_rst_done", {15'b0, done}, 16'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      nd = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("t5_no_done_after_rst", 16'(nd), 16'd0);
      chk("t5_p_after_rst", p, 16'h0000);

      // Random operands, randomly idle or back-to-back.
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         start_op(8'($urandom), 8'($urandom), 1'b1);
         wait_done(n);
         chk("rand_busy_cycles", 16'(n), 16'd8);
      end

      repeat (2) @(negedge clk);
      chk("sb_empty", 16'(sb.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
